// File: rtl/super_pixel_readout_param_pkg.sv
// Shared packet-field helpers for the super-pixel readout manager:
// width arithmetic, packet pack/unpack and the source-select encoding.
package super_pixel_pkg;

  localparam int PKT_MAX_W = 64;

  typedef enum logic {
    SRC_LOCAL = 1'b0,
    SRC_UP    = 1'b1
  } src_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int data_w(input int addr_w, input int pix_w, input int ts_w,
                                input int tot_w, input int ftoa_w);
    return addr_w + pix_w + ts_w + tot_w + ftoa_w;
  endfunction

  // Fields must arrive zero-extended; the caller truncates to its DATA_W.
  function automatic logic [PKT_MAX_W-1:0] pack_pkt(
      input logic [PKT_MAX_W-1:0] addr, input logic [PKT_MAX_W-1:0] pix,
      input logic [PKT_MAX_W-1:0] ts, input logic [PKT_MAX_W-1:0] tot,
      input logic [PKT_MAX_W-1:0] ftoa,
      input int pix_w, input int ts_w, input int tot_w, input int ftoa_w);
    return (addr << (pix_w + ts_w + tot_w + ftoa_w)) |
           (pix  << (ts_w + tot_w + ftoa_w)) |
           (ts   << (tot_w + ftoa_w)) |
           (tot  << ftoa_w) |
           ftoa;
  endfunction

  function automatic logic [PKT_MAX_W-1:0] get_field(input logic [PKT_MAX_W-1:0] pkt,
                                                     input int lsb, input int w);
    return (pkt >> lsb) & ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/super_pixel_readout_param_if.sv
// Daisy-chain link: upstream packet input plus downstream packet output of one super pixel.
interface super_pixel_readout_param_if #(parameter int DATA_W = 26);
  logic              last_valid;
  logic [DATA_W-1:0] last_data;
  logic              shake_hands_last;
  logic              arbiter_valid;
  logic [DATA_W-1:0] arbiter_data;
  logic              shake_hands_next;

  modport master (
    input  last_valid, last_data, shake_hands_next,
    output shake_hands_last, arbiter_valid, arbiter_data
  );

  modport slave (
    output last_valid, last_data, shake_hands_next,
    input  shake_hands_last, arbiter_valid, arbiter_data
  );
endinterface

// File: rtl/super_pixel_readout_param_fifo.sv
// Single-clock local packet FIFO; pushing into a full FIFO is accepted when a pop frees a slot.
module sp_sync_fifo
  import super_pixel_pkg::*;
#(
  parameter int DATA_W     = 26,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/super_pixel_readout_param.sv
// Super-pixel readout manager: per-pixel hold registers / hit counters, round-robin
// arbitration into a local FIFO, and fair merge with the upstream daisy-chain stream.
module super_pixel_readout_param
  import super_pixel_pkg::*;
#(
  parameter int N_PIX      = 8,
  parameter int TS_W       = 9,
  parameter int TOT_W      = 8,
  parameter int FTOA_W     = 5,
  parameter int ADDR_COL_W = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = data_w(ADDR_COL_W, clog2(N_PIX), TS_W, TOT_W, FTOA_W)
) (
  input  logic                    clk_40MHz,
  input  logic                    rst_n,
  input  logic                    shutter,
  input  logic                    mode,
  input  logic [TS_W-1:0]         TimeStamp,
  input  logic [N_PIX-1:0]        pixel_mask,
  input  logic [ADDR_COL_W-1:0]   addr_col,
  input  logic [N_PIX-1:0]        hit_done,
  input  logic [N_PIX*TS_W-1:0]   timestamp_hit,
  input  logic [N_PIX*TOT_W-1:0]  ToT_data,
  input  logic [N_PIX*FTOA_W-1:0] FTOA,
  output logic [N_PIX-1:0]        pixel_ack,
  output logic [N_PIX-1:0]        lost_hit,
  output logic                    busy,
  super_pixel_readout_param_if.master link
);
  localparam int PIX_W = clog2(N_PIX);
  localparam logic [TOT_W-1:0] CNT_MAX = {TOT_W{1'b1}};

  logic                shutter_q;
  logic                mode_q;
  logic [N_PIX-1:0]    pending;
  logic [TS_W-1:0]     hold_ts   [N_PIX];
  logic [TOT_W-1:0]    hold_tot  [N_PIX];
  logic [FTOA_W-1:0]   hold_ftoa [N_PIX];
  logic [TOT_W-1:0]    cnt       [N_PIX];
  logic [PIX_W-1:0]    rr_ptr;
  src_e                turn;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;

  logic                shutter_rise;
  logic                mode_eff;
  logic                count_close;
  logic [N_PIX-1:0]    hit_ok;
  logic [N_PIX-1:0]    arb_clear;
  logic [N_PIX-1:0]    hold_busy;
  logic                arb_found;
  logic [PIX_W-1:0]    arb_idx;
  logic                push;
  logic [DATA_W-1:0]   push_pkt;
  logic                fifo_pop;
  logic [DATA_W-1:0]   fifo_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic                can_load;
  logic                sel_up;
  logic                load_en;

  // A hit arriving on the shutter rising edge already follows the newly requested mode.
  assign shutter_rise = shutter & ~shutter_q;
  assign mode_eff     = shutter_rise ? mode : mode_q;
  assign count_close  = shutter_q & ~shutter & mode_q;
  assign hit_ok       = hit_done & ~pixel_mask & {N_PIX{shutter}};

  // Round-robin search for the first pending pixel at or after rr_ptr
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_ptr;
    for (int k = 0; k < N_PIX; k++) begin
      if (!arb_found && pending[rr_ptr + PIX_W'(k)]) begin
        arb_found = 1'b1;
        arb_idx   = rr_ptr + PIX_W'(k);
      end else begin
        arb_found = arb_found;
      end
    end
  end

  assign push      = arb_found & (~fifo_full | fifo_pop);
  assign arb_clear = push ? (N_PIX'(1) << arb_idx) : '0;
  assign hold_busy = pending & ~arb_clear;
  assign push_pkt  = DATA_W'(pack_pkt(PKT_MAX_W'(addr_col), PKT_MAX_W'(arb_idx),
                                      PKT_MAX_W'(hold_ts[arb_idx]), PKT_MAX_W'(hold_tot[arb_idx]),
                                      PKT_MAX_W'(hold_ftoa[arb_idx]),
                                      PIX_W, TS_W, TOT_W, FTOA_W));

  // Hold registers, hit counters and the ack / lost-hit pulses
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      pixel_ack <= '0;
      lost_hit  <= '0;
      for (int i = 0; i < N_PIX; i++) begin
        hold_ts[i]   <= '0;
        hold_tot[i]  <= '0;
        hold_ftoa[i] <= '0;
        cnt[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < N_PIX; i++) begin
        pixel_ack[i] <= 1'b0;
        lost_hit[i]  <= 1'b0;
        if (arb_clear[i]) pending[i] <= 1'b0;
        if (count_close) begin
          cnt[i] <= '0;
          if (cnt[i] != '0) begin
            if (hold_busy[i]) begin
              lost_hit[i] <= 1'b1;
            end else begin
              hold_ts[i]   <= TimeStamp;
              hold_tot[i]  <= cnt[i];
              hold_ftoa[i] <= '0;
              pending[i]   <= 1'b1;
            end
          end
        end else if (hit_ok[i]) begin
          if (mode_eff) begin
            if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + TOT_W'(1);
          end else if (hold_busy[i]) begin
            lost_hit[i] <= 1'b1;
          end else begin
            hold_ts[i]   <= timestamp_hit[i*TS_W +: TS_W];
            hold_tot[i]  <= ToT_data[i*TOT_W +: TOT_W];
            hold_ftoa[i] <= FTOA[i*FTOA_W +: FTOA_W];
            pending[i]   <= 1'b1;
            pixel_ack[i] <= 1'b1;
          end
        end
      end
    end
  end

  sp_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_40MHz),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_pkt),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // When both sources are available the toggle decides; otherwise the lone source wins.
  assign can_load = ~out_valid | link.shake_hands_next;
  assign sel_up   = link.last_valid & (fifo_empty | (turn == SRC_UP));
  assign load_en  = can_load & (~fifo_empty | link.last_valid);
  assign fifo_pop = can_load & ~fifo_empty & ~sel_up;

  // Shutter/mode tracking, round-robin pointer and the output register
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      shutter_q <= 1'b0;
      mode_q    <= 1'b0;
      rr_ptr    <= '0;
      turn      <= SRC_LOCAL;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      shutter_q <= shutter;
      if (shutter_rise) mode_q <= mode;
      if (push) rr_ptr <= arb_idx + PIX_W'(1);
      if (can_load) begin
        out_valid <= load_en;
        if (sel_up) out_data <= link.last_data;
        else if (!fifo_empty) out_data <= fifo_data;
        if (load_en) turn <= (turn == SRC_UP) ? SRC_LOCAL : SRC_UP;
      end
    end
  end

  assign link.arbiter_valid    = out_valid;
  assign link.arbiter_data     = out_data;
  assign link.shake_hands_last = can_load & sel_up;
  assign busy                  = (|pending) | ~fifo_empty | out_valid;
endmodule
